compare_seq_unit: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for the branch stage. It generalises the fixed 32-bit signed comparator to any width, with a run-time signed/unsigned mode select.
- Operands are compared CHUNK bits per cycle, most-significant chunk first. This keeps the per-cycle compare path short for wide operands.
- A valid/ready handshake sits on both the input and output sides, so the block can sit between the decode/operand-fetch and branch-resolve stages under backpressure.

---
 rtl/compare_seq_unit.sv | 192 +++++++++++++++++++
 tb/tb_compare_seq_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_seq_unit.sv
// compare_seq_unit: multi-cycle magnitude comparator for the branch stage.
// The operands are compared CHUNK bits per cycle, starting with the most-significant
// chunk. A run-time signed_i selects a two's-complement or an unsigned compare.
// There is a valid/ready handshake on the input side and on the output side.
// Optional macro COMPARE_EARLY_EXIT_EN: when it is defined, the compare stops at the
// first differing chunk. When it is undefined (the default), every compare walks all
// NCHUNK chunks. A sticky flag then keeps the first verdict, so the latency does not
// depend on the data.
module compare_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             equal_o,
  output logic             alarger_o,
  output logic             blarger_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  // Reject parameter sets the chunk walk cannot handle.
  generate
    if (WIDTH < 2) begin : gWidthCheck
      $error("compare_seq_unit: WIDTH must be at least 2");
    end
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : gChunkCheck
      $error("compare_seq_unit: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [IDXW-1:0] index_q, index_d;
  logic equal_q, equal_d;
  logic aLarger_q, aLarger_d;
  logic bLarger_q, bLarger_d;

  logic [CHUNK-1:0] chunkA;
  logic [CHUNK-1:0] chunkB;
  logic chunkNe;
  logic chunkGt;

`ifndef COMPARE_EARLY_EXIT_EN
  logic decided_q, decided_d;
  logic aGt_q, aGt_d;
  logic hitNow;
  logic aGtNow;
`endif

  // Select the chunk pair that index_q points at and compare the two chunks unsigned.
  always_comb begin
    chunkA = '0;
    chunkB = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (index_q == IDXW'(c)) begin
        chunkA = opA_q[c*CHUNK +: CHUNK];
        chunkB = opB_q[c*CHUNK +: CHUNK];
      end
    end
    chunkNe = (chunkA != chunkB);
    chunkGt = (chunkA > chunkB);
  end

  // Next-state logic: accept in IDLE, walk the chunks in RUN, hold the result in DONE.
  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    index_d   = index_q;
    equal_d   = equal_q;
    aLarger_d = aLarger_q;
    bLarger_d = bLarger_q;
`ifndef COMPARE_EARLY_EXIT_EN
    decided_d = decided_q;
    aGt_d     = aGt_q;
    hitNow    = decided_q | chunkNe;
    aGtNow    = decided_q ? aGt_q : chunkGt;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          // Inverting the sign bit maps two's-complement order onto unsigned order.
          opA_d   = a_i ^ {signed_i, {(WIDTH-1){1'b0}}};
          opB_d   = b_i ^ {signed_i, {(WIDTH-1){1'b0}}};
          index_d = LAST_IDX;
`ifndef COMPARE_EARLY_EXIT_EN
          decided_d = 1'b0;
          aGt_d     = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef COMPARE_EARLY_EXIT_EN
        if (chunkNe) begin
          equal_d   = 1'b0;
          aLarger_d = chunkGt;
          bLarger_d = ~chunkGt;
          state_d   = DONE;
        end else if (index_q == '0) begin
          equal_d   = 1'b1;
          aLarger_d = 1'b0;
          bLarger_d = 1'b0;
          state_d   = DONE;
        end else begin
          index_d = index_q - IDXW'(1);
        end
`else
        decided_d = hitNow;
        aGt_d     = aGtNow;
        if (index_q == '0) begin
          equal_d   = ~hitNow;
          aLarger_d = hitNow & aGtNow;
          bLarger_d = hitNow & ~aGtNow;
          state_d   = DONE;
        end else begin
          index_d = index_q - IDXW'(1);
        end
`endif
      end
      DONE: begin
        if (ready_i) begin
          equal_d   = 1'b0;
          aLarger_d = 1'b0;
          bLarger_d = 1'b0;
          index_d   = LAST_IDX;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        equal_d   = 1'b0;
        aLarger_d = 1'b0;
        bLarger_d = 1'b0;
        index_d   = LAST_IDX;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      index_q   <= LAST_IDX;
      equal_q   <= 1'b0;
      aLarger_q <= 1'b0;
      bLarger_q <= 1'b0;
`ifndef COMPARE_EARLY_EXIT_EN
      decided_q <= 1'b0;
      aGt_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      index_q   <= index_d;
      equal_q   <= equal_d;
      aLarger_q <= aLarger_d;
      bLarger_q <= bLarger_d;
`ifndef COMPARE_EARLY_EXIT_EN
      decided_q <= decided_d;
      aGt_q     <= aGt_d;
`endif
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign valid_o   = (state_q == DONE);
  assign equal_o   = equal_q;
  assign alarger_o = aLarger_q;
  assign blarger_o = bLarger_q;

endmodule

// File: tb/tb_compare_seq_unit.sv
// tb_compare_seq_unit: scoreboard bench for compare_seq_unit (WIDTH=32, CHUNK=8).
// Expected flags and latency come from a reference model and are queued at accept.
// A monitor pops them when valid_o rises.
module tb_compare_seq_unit;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             signed_i;
  logic             valid_o;
  logic             ready_i;
  logic             equal_o;
  logic             alarger_o;
  logic             blarger_o;

  typedef struct {
    logic eq;
    logic ag;
    logic bg;
    int   lat;
    int   acceptCycle;
  } exp_t;

  exp_t sbQ[$];
  int errors = 0;
  int checks = 0;
  int cycleCount = 0;
  logic prevValid = 1'b0;

  compare_seq_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .signed_i (signed_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .equal_o  (equal_o),
    .alarger_o(alarger_o),
    .blarger_o(blarger_o)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter, used to measure latency.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Reference model: the relation under the selected mode, and the number of chunks examined.
  function automatic exp_t modelOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s);
    exp_t e;
    logic agt;
    logic found;
    if (s) agt = ($signed(a) > $signed(b));
    else   agt = (a > b);
    e.eq = (a == b);
    e.ag = agt;
    e.bg = !agt && (a != b);
    e.lat = NCHUNK;
    e.acceptCycle = 0;
`ifdef COMPARE_EARLY_EXIT_EN
    found = 1'b0;
    for (int c = NCHUNK - 1; c >= 0; c--) begin
      if (!found && (a[c*CHUNK +: CHUNK] != b[c*CHUNK +: CHUNK])) begin
        found = 1'b1;
        e.lat = NCHUNK - c;
      end
    end
`else
    found = 1'b0;
`endif
    if (found) e.acceptCycle = 0;
    return e;
  endfunction

  // Monitor: checks each new result against the scoreboard, and checks the flag encoding every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_o === 1'b1 && prevValid !== 1'b1) begin
        checks++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_result: got valid_o=1 with flags %b, required no result",
                   {equal_o, alarger_o, blarger_o});
        end else begin
          e = sbQ.pop_front();
          checks++;
          if ({equal_o, alarger_o, blarger_o} !== {e.eq, e.ag, e.bg}) begin
            errors++;
            $display("[TB] FAIL result_flags: got eq/ag/bg=%b, required %b",
                     {equal_o, alarger_o, blarger_o}, {e.eq, e.ag, e.bg});
          end
          checks++;
          if ((cycleCount - e.acceptCycle) !== e.lat) begin
            errors++;
            $display("[TB] FAIL latency: got %0d edges, required %0d",
                     cycleCount - e.acceptCycle, e.lat);
          end
        end
      end
      checks++;
      if (valid_o === 1'b1) begin
        if (!$onehot({equal_o, alarger_o, blarger_o})) begin
          errors++;
          $display("[TB] FAIL flag_onehot: got %b, required exactly one set",
                   {equal_o, alarger_o, blarger_o});
        end
      end else if ({equal_o, alarger_o, blarger_o} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL flag_idle: got %b with valid_o=%b, required 000",
                 {equal_o, alarger_o, blarger_o}, valid_o);
      end
      prevValid = valid_o;
    end
  end

  // Drives one operand pair, which is accepted on the next edge, and queues its expected result.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic s);
    exp_t e;
    e = modelOp(a, b, s);
    e.acceptCycle = cycleCount + 1;
    sbQ.push_back(e);
    a_i = a;
    b_i = b;
    signed_i = s;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  // Waits a bounded number of cycles for valid_o and reports whether it arrived.
  task automatic waitResult(output bit got);
    got = 1'b0;
    for (int i = 0; i < 3 * NCHUNK + 4; i++) begin
      if (!got) begin
        @(negedge clk);
        if (valid_o === 1'b1) got = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready_o, valid_o, equal_o, alarger_o, blarger_o} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_state: got rdy/vld/eq/ag/bg=%b, required 10000",
               {ready_o, valid_o, equal_o, alarger_o, blarger_o});
    end
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({ready_o, valid_o} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got rdy/vld=%b, required 10", {ready_o, valid_o});
    end
  endtask

  task automatic test_compare_table();
    logic [31:0] ta[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678,
                           32'h80000000, 32'h12345679};
    logic [31:0] tb[6] = '{32'h00000001, 32'h00000001, 32'h12345678, 32'h12345678,
                           32'h7FFFFFFF, 32'h12345678};
    logic ts[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bit got;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL table_ready[%0d]: got ready_o=%b, required 1", i, ready_o);
      end
      applyStimulus(ta[i], tb[i], ts[i]);
      waitResult(got);
      checks++;
      if (!got) begin
        errors++;
        $display("[TB] FAIL table_timeout[%0d]: got no valid_o, required a result", i);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({ready_o, valid_o} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL table_release[%0d]: got rdy/vld=%b, required 10", i, {ready_o, valid_o});
      end
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    logic [31:0] a;
    logic [31:0] b;
    int sel;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0) b = a;
      else if (sel == 1) b = a ^ (32'h1 << $urandom_range(0, 31));
      else b = $urandom;
      applyStimulus(a, b, 1'($urandom_range(0, 1)));
      waitResult(got);
      checks++;
      if (!got) begin
        errors++;
        $display("[TB] FAIL b2b_timeout[%0d]: got no valid_o, required a result", i);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_ready[%0d]: got ready_o=%b, required 1", i, ready_o);
      end
    end
  endtask

  task automatic test_backpressure();
    bit got;
    ready_i = 1'b0;
    applyStimulus(32'd10, 32'd3, 1'b0);
    waitResult(got);
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL bp_timeout: got no valid_o, required a result");
    end
    @(posedge clk);
    #1;
    valid_i = 1'b1;
    a_i = 32'd1;
    b_i = 32'd2;
    signed_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({valid_o, ready_o, equal_o, alarger_o, blarger_o} !== 5'b10010) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got vld/rdy/eq/ag/bg=%b, required 10010",
                 i, {valid_o, ready_o, equal_o, alarger_o, blarger_o});
      end
      @(posedge clk);
      #1;
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({valid_o, ready_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_release: got vld/rdy=%b, required 01", {valid_o, ready_o});
    end
    applyStimulus(32'd1, 32'd2, 1'b0);
    waitResult(got);
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL bp_next_timeout: got no valid_o, required a result");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    bit got;
    applyStimulus(32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    sbQ.delete(sbQ.size() - 1);
    checks++;
    if ({ready_o, valid_o, equal_o, alarger_o, blarger_o} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL run_abort: got rdy/vld/eq/ag/bg=%b, required 10000",
               {ready_o, valid_o, equal_o, alarger_o, blarger_o});
    end
    for (int i = 0; i < NCHUNK + 1; i++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL run_abort_quiet[%0d]: got valid_o=%b, required 0", i, valid_o);
      end
    end
    @(posedge clk);
    #1;
    applyStimulus(32'd5, 32'd3, 1'b0);
    waitResult(got);
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL after_abort_timeout: got no valid_o, required a result");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_done();
    bit got;
    ready_i = 1'b0;
    applyStimulus(32'd3, 32'd5, 1'b0);
    waitResult(got);
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL done_timeout: got no valid_o, required a result");
    end
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    ready_i = 1'b1;
    checks++;
    if ({ready_o, valid_o, equal_o, alarger_o, blarger_o} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL done_abort: got rdy/vld/eq/ag/bg=%b, required 10000",
               {ready_o, valid_o, equal_o, alarger_o, blarger_o});
    end
  endtask

  // Test sequence.
  initial begin
    rst_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    a_i = '0;
    b_i = '0;
    signed_i = 1'b0;
    test_reset();
    test_compare_table();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_reset_in_done();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending results, required 0", sbQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
